// File: rtl/lemming_world.sv
// Corridor model around the lemming walker: tracks the lemming's cell, returns wall bumps,
// counts bounces (only when LEMMING_BOUNCE_CNT_EN is defined) and flags illegal walker outputs.
//
// state | meaning
// IDLE  | no step this cycle (move_en low or illegal direction)
// STEP  | move_en high with exactly one walk direction; move or bump
module lemming_world #(
    parameter int LEN   = 10,
    parameter int POS_W = 4,
    parameter int START = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_en,
    input  logic             walk_left,
    input  logic             walk_right,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic [CNT_W-1:0] bounces,
    output logic             fault
);

    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(LEN - 1);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START);

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } mode_t;

    mode_t            mode;
    logic             legal;
    logic             at_left;
    logic             at_right;
    logic [POS_W-1:0] pos_next;
    logic             fault_next;

    assign legal    = walk_left ^ walk_right;
    assign at_left  = (pos == '0);
    assign at_right = (pos == LAST_POS);

    always_ff @(posedge clk) begin
        if (reset) begin
            pos   <= START_POS;
            fault <= 1'b0;
        end else begin
            pos   <= pos_next;
            fault <= fault_next;
        end
    end

    always_comb begin
        mode       = IDLE;
        pos_next   = pos;
        fault_next = fault;
        if (move_en && legal) begin
            mode = STEP;
        end
        if (move_en && !legal) begin
            fault_next = 1'b1;
        end
        if (mode == STEP) begin
            if (walk_left && !at_left) begin
                pos_next = pos - 1'b1;
            end else if (walk_right && !at_right) begin
                pos_next = pos + 1'b1;
            end
        end
    end

    // Bumps are combinational so a Moore walker sees them at the same edge they occur.
    always_comb begin
        bump_left  = 1'b0;
        bump_right = 1'b0;
        if (!reset && mode == STEP) begin
            bump_left  = walk_left && at_left;
            bump_right = walk_right && at_right;
        end
    end

`ifdef LEMMING_BOUNCE_CNT_EN
    logic             hit;
    logic [CNT_W-1:0] bounce_cnt;

    assign hit = bump_left | bump_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            bounce_cnt <= '0;
        end else if (hit && bounce_cnt != '1) begin
            bounce_cnt <= bounce_cnt + 1'b1;
        end
    end

    assign bounces = bounce_cnt;
`else
    assign bounces = '0;
`endif

endmodule

// File: tb/tb_lemming_world.sv
// Self-checking bench for lemming_world: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural corridor model.
module tb_lemming_world;

    localparam int LEN   = 4;
    localparam int POS_W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_en = 1'b0;
    logic       walk_left = 1'b0;
    logic       walk_right = 1'b0;

    logic       bump_left, bump_right, fault;
    logic [POS_W-1:0] pos;
    logic [7:0] bounces;
    logic       s_bump_left, s_bump_right, s_fault;
    logic [POS_W-1:0] s_pos;
    logic [1:0] s_bounces;

    int tests = 0;
    int fails = 0;

    lemming_world #(.LEN(LEN), .POS_W(POS_W), .START(0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .move_en(move_en),
        .walk_left(walk_left), .walk_right(walk_right),
        .bump_left(bump_left), .bump_right(bump_right),
        .pos(pos), .bounces(bounces), .fault(fault)
    );

    lemming_world #(.LEN(LEN), .POS_W(POS_W), .START(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .move_en(move_en),
        .walk_left(walk_left), .walk_right(walk_right),
        .bump_left(s_bump_left), .bump_right(s_bump_right),
        .pos(s_pos), .bounces(s_bounces), .fault(s_fault)
    );

    always #5 clk = ~clk;

    function automatic int cnt_exp(input int n);
`ifdef LEMMING_BOUNCE_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural corridor model: position, bounce counts for both counter widths, fault flag.
    int m_pos = 0, m_b8 = 0, m_b2 = 0;
    bit m_fault = 0, m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos   <= 0;
            m_b8    <= 0;
            m_b2    <= 0;
            m_fault <= 0;
            m_valid <= 1;
        end else if (move_en) begin
            if (walk_left == walk_right) begin
                m_fault <= 1;
            end else if (walk_left) begin
                if (m_pos == 0) begin
                    m_b8 <= (m_b8 < 255) ? m_b8 + 1 : 255;
                    m_b2 <= (m_b2 < 3) ? m_b2 + 1 : 3;
                end else begin
                    m_pos <= m_pos - 1;
                end
            end else begin
                if (m_pos == LEN - 1) begin
                    m_b8 <= (m_b8 < 255) ? m_b8 + 1 : 255;
                    m_b2 <= (m_b2 < 3) ? m_b2 + 1 : 3;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            automatic bit legal = walk_left ^ walk_right;
            automatic bit e_bl = !reset && move_en && legal && walk_left && (m_pos == 0);
            automatic bit e_br = !reset && move_en && legal && walk_right && (m_pos == LEN - 1);
            check("pos", int'(pos), m_pos);
            check("fault", int'(fault), int'(m_fault));
            check("bump_left", int'(bump_left), int'(e_bl));
            check("bump_right", int'(bump_right), int'(e_br));
            check("bounces", int'(bounces), cnt_exp(m_b8));
            check("sat_pos", int'(s_pos), m_pos);
            check("sat_bounces", int'(s_bounces), cnt_exp(m_b2));
            check("sat_bumps", int'({s_bump_left, s_bump_right}), int'({e_bl, e_br}));
        end
    end

    task automatic drive(input logic r, input logic me, input logic wl, input logic wr);
        reset = r;
        move_en = me;
        walk_left = wl;
        walk_right = wr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_pos[4];
        int loop_pos[12];
        bit dir_left;

        drive(1, 0, 0, 0);
        tick;
        tick;
        check("rst_pos", int'(pos), 0);
        check("rst_bounces", int'(bounces), 0);
        check("rst_fault", int'(fault), 0);

        // Left into the wall straight after reset.
        drive(0, 1, 1, 0);
        @(negedge clk);
        check("lit_bump_left", int'(bump_left), 1);
        check("lit_bump_right", int'(bump_right), 0);
        tick;
        check("lit_pos_after_bump", int'(pos), 0);
        check("lit_bounces_1", int'(bounces), cnt_exp(1));

        // Walk right to the far wall.
        exp_pos = '{1, 2, 3, 3};
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 1);
            @(negedge clk);
            check("lit_right_bump", int'(bump_right), (k == 3) ? 1 : 0);
            tick;
            check("lit_right_pos", int'(pos), exp_pos[k]);
        end
        check("lit_bounces_2", int'(bounces), cnt_exp(2));

        // Illegal direction at pos 2.
        drive(0, 1, 1, 0);
        tick;
        drive(0, 1, 1, 1);
        @(negedge clk);
        check("lit_fault_nobump", int'({bump_left, bump_right}), 0);
        tick;
        check("lit_fault_set", int'(fault), 1);
        check("lit_fault_pos", int'(pos), 2);
        drive(0, 1, 1, 0);
        tick;
        check("lit_fault_sticky", int'(fault), 1);
        check("lit_fault_legal_pos", int'(pos), 1);
        drive(0, 1, 0, 1);
        tick;

        // Reset wins over a pending step.
        drive(1, 1, 1, 0);
        @(negedge clk);
        check("lit_rst_nobump", int'({bump_left, bump_right}), 0);
        tick;
        check("lit_rst_pos", int'(pos), 0);
        check("lit_rst_bounces", int'(bounces), 0);
        check("lit_rst_fault", int'(fault), 0);

        // Saturation on the 2-bit counter.
        exp_pos = '{1, 2, 3, 3};
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 1, 0);
            tick;
            check("lit_sat_bounces", int'(s_bounces), cnt_exp(k < 3 ? exp_pos[k] : 3));
            check("lit_wide_bounces", int'(bounces), cnt_exp(k + 1));
        end

        // Closed loop with a Moore walker that resets walking left.
        drive(1, 0, 0, 0);
        tick;
        loop_pos = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
        dir_left = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bit bl, br;
            drive(0, 1, dir_left, !dir_left);
            @(negedge clk);
            bl = bump_left;
            br = bump_right;
            check("loop_bump_left", int'(bl), (c == 0 || c == 8) ? 1 : 0);
            check("loop_bump_right", int'(br), (c == 4) ? 1 : 0);
            tick;
            check("loop_pos", int'(pos), loop_pos[c]);
            if (c == 8) check("loop_bounces", int'(bounces), cnt_exp(3));
            if (bl) dir_left = 1'b0;
            if (br) dir_left = 1'b1;
        end

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            automatic int d = $urandom_range(0, 7);
            automatic logic wl, wr;
            if (d == 0) begin
                wl = 1'b1; wr = 1'b1;
            end else if (d == 1) begin
                wl = 1'b0; wr = 1'b0;
            end else begin
                wl = d[0]; wr = !d[0];
            end
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, wl, wr);
            tick;
        end

        drive(0, 0, 0, 0);
        tick;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
